// File: rtl/mux_sched_pkg.sv
// Shared constants, the state encoding and a wrap-increment helper for the
// round-robin scheduler that drives the 31-input shared mux.
package mux_sched_pkg;

  localparam int NUM_REQ  = 31;
  localparam int SEL_W    = 5;
  localparam int CNT_W    = 4;
  localparam int LAST_IDX = NUM_REQ - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Next requester index. Index 30 wraps to 0, so the mux default region
  // (select 31) can never be reached.
  function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(LAST_IDX)) ? '0 : idx + 1'b1;
  endfunction

  // One-hot grant vector for a select index.
  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority search: the winner is the lowest asserted request at an
// index >= ptr. If there is none, the search wraps to the lowest asserted
// request overall. win_vld is low when no request is asserted.
module mux_rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   win_idx,
  output logic               win_vld
);

  logic [NUM_REQ-1:0] at_or_above;
  logic [NUM_REQ-1:0] hi_req;

  // Mask of indices at or above the pointer. These are searched first.
  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_mask
      assign at_or_above[g] = (SEL_W'(g) >= ptr);
    end
  endgenerate

  assign hi_req = req & at_or_above;

  logic [SEL_W-1:0] hi_idx, lo_idx;
  logic             hi_vld, lo_vld;

  // Two priority encoders, scanned from the top so the lowest hit wins.
  always_comb begin
    hi_idx = '0;
    hi_vld = 1'b0;
    lo_idx = '0;
    lo_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi_req[i]) begin
        hi_idx = SEL_W'(i);
        hi_vld = 1'b1;
      end
      if (req[i]) begin
        lo_idx = SEL_W'(i);
        lo_vld = 1'b1;
      end
    end
  end

  assign win_vld = lo_vld;
  assign win_idx = hi_vld ? hi_idx : lo_idx;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin burst scheduler for the shared 31-input mux. An owner keeps the
// mux for up to BURST_LEN accepted beats. It releases early if its request
// drops or if enable falls. On release the next owner is chosen in the same
// cycle, so back-to-back grants have no bubble.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               out_valid,
  output logic               busy
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] win_idx;
  logic             win_vld;
  logic             accept;
  logic             last_beat;
  logic             rel;

  assign sel_nxt   = idx_inc(sel);
  assign accept    = out_valid & out_ready;
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign rel       = (state == SERVE) & accept & (last_beat | ~req[sel] | ~enable);

  // While serving, the only pick that matters is the one at release. That
  // pick uses the post-release pointer (sel+1), so the single search
  // instance is fed the new pointer directly.
  assign pick_ptr = (state == SERVE) ? sel_nxt : ptr;

  mux_rr_pick u_pick (
    .req     (req),
    .ptr     (pick_ptr),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // FSM with registered mux select, grant and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ptr       <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && win_vld) begin
            state     <= SERVE;
            sel       <= win_idx;
            grant     <= idx_onehot(win_idx);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            beat_cnt  <= '0;
          end
        end
        SERVE: begin
          // Without an accept, everything holds. The beat stays offered
          // even if the owner's request has dropped.
          if (accept) begin
            if (rel) begin
              ptr <= sel_nxt;
              if (enable && win_vld) begin
                sel      <= win_idx;
                grant    <= idx_onehot(win_idx);
                beat_cnt <= '0;
              end else begin
                state     <= IDLE;
                grant     <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: reset, single-owner re-grant, pointer
// wrap, backpressure, early request drop and enable gating.
module tb_mux_rr_sched;
  import mux_sched_pkg::*;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               out_ready;
  logic [SEL_W-1:0]   sel;
  logic [NUM_REQ-1:0] grant;
  logic               out_valid;
  logic               busy;

  int checks = 0;
  int errors = 0;

  mux_rr_sched #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expect owner s: sel, one-hot grant, valid and busy.
  task automatic chk_own(input string tag, input int s);
    logic [NUM_REQ-1:0] g;
    g = '0;
    g[s] = 1'b1;
    chk({tag, ".sel"},   32'(sel),       32'(s));
    chk({tag, ".grant"}, 32'(grant),     32'(g));
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".busy"},  32'(busy),      32'd1);
  endtask

  // Expect idle: no grant, no valid, not busy, sel holding s.
  task automatic chk_idle(input string tag, input int s);
    chk({tag, ".sel"},   32'(sel),       32'(s));
    chk({tag, ".grant"}, 32'(grant),     32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".busy"},  32'(busy),      32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #1;
    chk_idle("rst_init", 0);
    tick(1);
    reset = 1'b0;

    // Single requester 12: 4 accepted beats, then re-granted with no idle cycle.
    enable    = 1'b1;
    out_ready = 1'b1;
    req       = '0;
    req[12]   = 1'b1;
    tick(1);
    chk_own("single_b0", 12);
    chk("single_grant_hex", 32'(grant), 32'h0000_1000);
    tick(3);
    chk_own("single_b3", 12);
    tick(1);
    chk_own("single_regrant", 12);
    tick(1);

    // Reset mid-SERVE clears the outputs asynchronously.
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rst_async", 0);
    req = '0;
    tick(1);
    reset = 1'b0;
    tick(2);
    chk_idle("rst_after", 0);

    // Wrap: requesters 0 and 30 alternate, 4 beats each.
    req     = '0;
    req[0]  = 1'b1;
    req[30] = 1'b1;
    tick(1);
    chk_own("wrap_0a", 0);
    tick(3);
    chk_own("wrap_0a_last", 0);
    tick(1);
    chk_own("wrap_30", 30);
    tick(3);
    chk_own("wrap_30_last", 30);
    tick(1);
    chk_own("wrap_0b", 0);

    // Backpressure: owner 7 held at beat 1 for 5 cycles. The burst then
    // finishes beats 1..3 and hands over to 8.
    req = '0;
    do_reset();
    req[7] = 1'b1;
    req[8] = 1'b1;
    out_ready = 1'b1;
    tick(1);
    chk_own("bp_start", 7);
    tick(1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_own($sformatf("bp_hold%0d", i), 7);
    end
    out_ready = 1'b1;
    tick(2);
    chk_own("bp_beat3", 7);
    tick(1);
    chk_own("bp_next", 8);

    // Early drop: owner 5 loses its request after 2 beats. The offered beat
    // is not retracted; on its accept the grant moves on to 9.
    req = '0;
    do_reset();
    req[5] = 1'b1;
    req[9] = 1'b1;
    out_ready = 1'b1;
    tick(1);
    chk_own("drop_start", 5);
    tick(2);
    req[5]    = 1'b0;
    out_ready = 1'b0;
    tick(1);
    chk_own("drop_hold", 5);
    out_ready = 1'b1;
    tick(1);
    chk_own("drop_next", 9);

    // Enable gating: no grants while low, then 0,1,2 in order.
    req = '0;
    do_reset();
    enable    = 1'b0;
    req       = '1;
    out_ready = 1'b1;
    tick(2);
    chk_idle("en_off", 0);
    enable = 1'b1;
    tick(1);
    chk_own("en_g0", 0);
    tick(3);
    chk_own("en_g0_last", 0);
    tick(1);
    chk_own("en_g1", 1);
    tick(3);
    chk_own("en_g1_last", 1);
    tick(1);
    chk_own("en_g2", 2);
    tick(1);
    // Enable falls mid-burst: the pending beat completes, then idle.
    enable = 1'b0;
    tick(1);
    chk_idle("en_drop", 2);
    tick(2);
    chk_idle("en_stay", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
